// File: rtl/line_table_writer_pkg.sv
// -----------------------------------------------------------------------------
// line_pkg: shared definitions for the line table writer and its reader side.
//   state_e     : writer FSM states (expect x half, expect y half, table full)
//   pack_halves : packs an x half above a y half, for any half width
//                 up to MAX_HALF_W; callers size-cast the result to W bits.
// -----------------------------------------------------------------------------
package line_pkg;

   typedef enum logic [1:0] {
      S_X    = 2'd0,
      S_Y    = 2'd1,
      S_FULL = 2'd2
   } state_e;

   localparam int MAX_HALF_W = 32;

   // x lands at bit half_w and above, y fills the bits below it.
   function automatic logic [2*MAX_HALF_W-1:0] pack_halves(
      input logic [MAX_HALF_W-1:0] x,
      input logic [MAX_HALF_W-1:0] y,
      input int unsigned           half_w
   );
      pack_halves = ({{MAX_HALF_W{1'b0}}, x} << half_w) | {{MAX_HALF_W{1'b0}}, y};
   endfunction

endpackage

// File: rtl/line_table_writer_if.sv
// -----------------------------------------------------------------------------
// line_table_writer_if: half-word stream into the line table writer.
//   in_valid : a half-word is presented (master -> slave)
//   in_data  : W/2-bit half-word payload (master -> slave)
//   in_last  : on an x half, closes the line early with y = 0 (master -> slave)
//   in_ready : writer can accept a half-word this cycle (slave -> master)
// -----------------------------------------------------------------------------
interface line_table_writer_if #(
   parameter int W = 8
);
   logic           in_valid;
   logic           in_ready;
   logic [W/2-1:0] in_data;
   logic           in_last;

   modport master (output in_valid, output in_data, output in_last, input in_ready);
   modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/line_table_writer.sv
// -----------------------------------------------------------------------------
// line_table_writer: builds DEPTH packed lines {x, y} from a stream of half
// words (x first, then y) and commits each to the next free table entry.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   clr         : synchronous table clear, same effect as rst
//   in_if       : half-word stream (slave side)
//   table_out   : DEPTH lines, entry 0 = first written, uncommitted = 0
//   valid_mask  : bit i set once entry i holds a committed line
//   wr_ptr      : index of the next entry to be written
//   full        : all DEPTH entries committed; input stalls until rst/clr
// -----------------------------------------------------------------------------
module line_table_writer
   import line_pkg::*;
#(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          clr,
   line_table_writer_if.slave            in_if,
   output logic [DEPTH-1:0][W-1:0]       table_out,
   output logic [DEPTH-1:0]              valid_mask,
   output logic [$clog2(DEPTH)-1:0]      wr_ptr,
   output logic                          full
);

   localparam int HALF_W = W / 2;
   localparam int PTR_W  = $clog2(DEPTH);
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

   // Field order must match the reader's declaration of the same struct.
   typedef struct packed {
      logic [HALF_W-1:0] x;
      logic [HALF_W-1:0] y;
   } line_t;

   state_e                    state_q, state_d;
   logic [PTR_W-1:0]          ptr_q, ptr_d;
   logic                      full_q, full_d;
   logic [HALF_W-1:0]         stage_q, stage_d;
   line_t [DEPTH-1:0]         table_q;
   logic [DEPTH-1:0]          valid_q;
   logic                      commit;
   line_t                     line_d;
   logic                      xfer;

   assign xfer = in_if.in_valid && in_if.in_ready;

   // Ready depends only on reset/clear and the registered state.
   always_comb begin
      in_if.in_ready = !rst && !clr && (state_q != S_FULL);
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      full_d  = full_q;
      stage_d = stage_q;
      commit  = 1'b0;
      line_d  = '0;
      if (xfer) begin
         case (state_q)
            S_X: begin
               if (in_if.in_last) begin
                  commit = 1'b1;
                  line_d = line_t'(W'(pack_halves(MAX_HALF_W'(in_if.in_data), '0, HALF_W)));
               end else begin
                  stage_d = in_if.in_data;
                  state_d = S_Y;
               end
            end
            S_Y: begin
               commit = 1'b1;
               line_d = line_t'(W'(pack_halves(MAX_HALF_W'(stage_q),
                                               MAX_HALF_W'(in_if.in_data), HALF_W)));
            end
            default: ;
         endcase
      end
      // The last entry parks the pointer and stops intake; no wrap-around.
      if (commit) begin
         if (ptr_q == LAST_IDX) begin
            full_d  = 1'b1;
            state_d = S_FULL;
         end else begin
            ptr_d   = ptr_q + 1'b1;
            state_d = S_X;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         state_q <= S_X;
         ptr_q   <= '0;
         full_q  <= 1'b0;
         stage_q <= '0;
         table_q <= '0;
         valid_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         full_q  <= full_d;
         stage_q <= stage_d;
         if (commit) begin
            table_q[ptr_q] <= line_d;
            valid_q[ptr_q] <= 1'b1;
         end
      end
   end

   assign table_out  = table_q;
   assign valid_mask = valid_q;
   assign wr_ptr     = ptr_q;
   assign full       = full_q;

endmodule

// File: tb/tb_line_table_writer.sv
module tb_line_table_writer;
   localparam int W     = 8;
   localparam int DEPTH = 4;
   localparam int HW    = W / 2;
   localparam int PW    = $clog2(DEPTH);

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    clr;
   logic [DEPTH-1:0][W-1:0] table_out;
   logic [DEPTH-1:0]        valid_mask;
   logic [PW-1:0]           wr_ptr;
   logic                    full;

   line_table_writer_if #(.W(W)) bus ();

   line_table_writer #(.W(W), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .clr        (clr),
      .in_if      (bus),
      .table_out  (table_out),
      .valid_mask (valid_mask),
      .wr_ptr     (wr_ptr),
      .full       (full)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference: list of committed lines in write order, plus a pending x half.
   logic [W-1:0]  mdl_lines[$];
   bit            mdl_have_x = 1'b0;
   logic [HW-1:0] mdl_x      = '0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      logic [DEPTH-1:0][W-1:0] exp_tbl;
      logic [DEPTH-1:0]        exp_mask;
      int                      n;
      n = mdl_lines.size();
      exp_tbl  = '0;
      exp_mask = '0;
      for (int i = 0; i < n; i++) begin
         exp_tbl[i]  = mdl_lines[i];
         exp_mask[i] = 1'b1;
      end
      check_eq("table_out",  table_out,  exp_tbl);
      check_eq("valid_mask", valid_mask, exp_mask);
      check_eq("wr_ptr",     wr_ptr,     (n == DEPTH) ? DEPTH - 1 : n);
      check_eq("full",       full,       n == DEPTH);
   endtask

   // Drive one cycle, check ready before the edge and all registered outputs after.
   task automatic cycle(input bit v, input logic [HW-1:0] d, input bit l,
                        input bit r, input bit c);
      bit exp_rdy;
      bus.in_valid = v;
      bus.in_data  = d;
      bus.in_last  = l;
      rst          = r;
      clr          = c;
      #1;
      exp_rdy = !r && !c && (mdl_lines.size() < DEPTH);
      check_eq("in_ready", bus.in_ready, exp_rdy);
      if (r || c) begin
         mdl_lines.delete();
         mdl_have_x = 1'b0;
      end else if (v && exp_rdy) begin
         if (!mdl_have_x) begin
            if (l) mdl_lines.push_back({d, {HW{1'b0}}});
            else begin
               mdl_have_x = 1'b1;
               mdl_x      = d;
            end
         end else begin
            mdl_lines.push_back({mdl_x, d});
            mdl_have_x = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic send(input logic [HW-1:0] d, input bit l);
      cycle(1'b1, d, l, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.in_last  = 1'b0;
      rst          = 1'b1;
      clr          = 1'b0;

      do_reset();
      do_reset();
      check_eq("reset_table", table_out, '0);
      check_eq("reset_mask", valid_mask, '0);

      // Basic pair
      send(4'h4, 1'b0);
      send(4'h3, 1'b0);
      check_eq("basic_entry0", table_out[0], 8'h43);
      check_eq("basic_mask", valid_mask, 4'b0001);
      check_eq("basic_ptr", wr_ptr, 1);

      // Fill to full, then hammer with data while full
      send(4'h1, 1'b0); send(4'h6, 1'b0);
      send(4'h8, 1'b0); send(4'hF, 1'b0);
      send(4'h6, 1'b0); send(4'h6, 1'b0);
      check_eq("fill_table", table_out, 32'h668F1643);
      check_eq("fill_mask", valid_mask, 4'hF);
      check_eq("fill_full", full, 1'b1);
      check_eq("fill_ready", bus.in_ready, 1'b0);
      for (int i = 0; i < 5; i++) send(4'h9, 1'b0);
      check_eq("full_hold_table", table_out, 32'h668F1643);
      check_eq("full_hold_ptr", wr_ptr, DEPTH - 1);

      // Reset while full
      do_reset();
      check_eq("rst_full_table", table_out, '0);
      check_eq("rst_full_flag", full, 1'b0);
      check_eq("rst_full_ptr", wr_ptr, 0);
      cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
      check_eq("ready_after_rst", bus.in_ready, 1'b1);

      // Early close
      send(4'hA, 1'b1);
      send(4'h5, 1'b0);
      send(4'h7, 1'b1);   // last ignored on a y half
      check_eq("early_entry0", table_out[0], 8'hA0);
      check_eq("early_entry1", table_out[1], 8'h57);
      check_eq("early_ptr", wr_ptr, 2);

      // Clear mid-line
      send(4'hC, 1'b0);
      cycle(1'b1, 4'hD, 1'b0, 1'b0, 1'b1);
      check_eq("clr_table", table_out, '0);
      check_eq("clr_mask", valid_mask, '0);
      send(4'h2, 1'b0);
      send(4'h1, 1'b0);
      check_eq("clr_entry0", table_out[0], 8'h21);
      check_eq("clr_mask_after", valid_mask, 4'b0001);

      // Gaps between halves
      do_reset();
      send(4'hB, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 4'($urandom), 1'($urandom), 1'b0, 1'b0);
         check_eq("gap_mask", valid_mask, '0);
      end
      send(4'hE, 1'b0);
      check_eq("gap_entry0", table_out[0], 8'hBE);

      // Randomized traffic with occasional clear/reset
      for (int i = 0; i < 600; i++) begin
         cycle(($urandom % 4) != 0, 4'($urandom), ($urandom % 5) == 0,
               ($urandom % 64) == 0, ($urandom % 24) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/line_table_writer.md
Name: line_table_writer

Overview:
- Fills a DEPTH-entry table of packed lines from a stream of half-width words. Each line has two fields, x (upper half) and y (lower half).
- Every two accepted words form one line: first word is x, second is y. The line is committed to the next free table entry.
- The packed table and a per-entry valid mask are driven to a downstream combinational line selector. That selector indexes entries and reads fields.
- This block is the write side; the selector only ever reads.

Parameters:
- W, 8, line width in bits. Must be even and >= 2. x = line[W-1:W/2], y = line[W/2-1:0].
- DEPTH, 4, number of table entries. Power of two, >= 2.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  a half-word is presented.
- in_ready  output  1  block can accept a half-word this cycle.
- in_data  input  W/2  half-word payload.
- in_last  input  1  when set on an x half, closes the line early with y = 0.
- clr  input  1  synchronous table clear; same effect as rst.
- table_out  output  DEPTH x W  packed array of line_t, index 0 = first written.
- valid_mask  output  DEPTH  bit i set when entry i holds a committed line.
- wr_ptr  output  $clog2(DEPTH)  index of the next entry to be written.
- full  output  1  all DEPTH entries are committed.

Behaviour:
- Reset and clear:
  - rst or clr: state = S_X, wr_ptr = 0, valid_mask = 0, full = 0, table_out = all zero, staging register = 0.
  - in_ready = 0 in the cycle rst or clr is high.
- Handshake:
  - A transfer occurs when in_valid && in_ready at a rising edge.
  - in_data and in_last are sampled only on a transfer.
  - in_ready = !rst && !clr && (state != S_FULL). It has no combinational dependence on in_valid.
- State S_X (expect x half), on transfer:
  - in_last = 0: staging <= in_data; go to S_Y.
  - in_last = 1: commit line {in_data, '0} to entry wr_ptr (see commit rules).
- State S_Y (expect y half), on transfer:
  - Commit line {staging, in_data} to entry wr_ptr. in_last is ignored.
- Commit rules:
  - table_out[wr_ptr] <= line; valid_mask[wr_ptr] <= 1.
  - If wr_ptr == DEPTH-1: full <= 1, state <= S_FULL, wr_ptr holds at DEPTH-1.
  - Otherwise: wr_ptr <= wr_ptr + 1, state <= S_X.
- State S_FULL:
  - No transfers. Outputs hold until rst or clr.
  - There is no wrap-around and no overwrite.
- Latency: a committed line appears on table_out and valid_mask in the cycle after its completing transfer.
- Uncommitted entries read as zero. A half-built line (x in staging) is never visible on table_out.
- Simultaneous events:
  - clr or rst with in_valid: no transfer (in_ready is low), and the staged x is discarded.
  - rst and clr together: identical to rst alone.
- Width rules:
  - wr_ptr is $clog2(DEPTH) bits; increment never overflows because S_FULL is entered at DEPTH-1.
  - The early-close zero fill is exactly W/2 bits.
- All outputs are registered except in_ready.

Decomposition:
- Shared package line_pkg:
  - State enum {S_X, S_Y, S_FULL}, 2-bit encoding.
  - A function packing two halves into a line.
- line_t depends on W, so it is declared inside the module as a packed struct {x, y}. The reader side uses the identical declaration so field order matches.
- No sub-module. One always_ff block covers state/pointer/table, plus one combinational in_ready assign.

Test Plan:
- Basic pair: after reset, send 4'h4 then 4'h3 with in_valid held high. Expect:
  - table_out[0] = 8'h43 one cycle after the second handshake.
  - valid_mask = 4'b0001, wr_ptr = 1.
- Fill to full: send halves 4,3,1,6,8,F,6,6. Expect:
  - table_out = {8'h66, 8'h8F, 8'h16, 8'h43} (entry 3 down to entry 0).
  - valid_mask = 4'hF, full = 1, in_ready = 0.
  - A further in_valid = 1 with 4'h9 for 5 cycles leaves all outputs unchanged.
- Early close: send 4'hA with in_last = 1 at entry 0, then 4'h5 then 4'h7. Expect:
  - table_out[0] = 8'hA0.
  - table_out[1] = 8'h57.
  - wr_ptr = 2.
- Clear mid-line: send 4'hC (x only), assert clr one cycle, then send 4'h2, 4'h1. Expect:
  - After clr: all outputs zero.
  - After the new pair: table_out[0] = 8'h21 (staged C discarded), valid_mask = 4'b0001.
- Backpressure/gaps: send x = 4'hB, drop in_valid for 3 cycles with junk in_data, then send y = 4'hE. Expect:
  - table_out[0] = 8'hBE.
  - No commit during the gap.
- Reset while full: from the full state, assert rst. Expect:
  - Next cycle: table_out = 0, valid_mask = 0, full = 0, wr_ptr = 0.
  - in_ready = 1 once rst is low.
